// File: rtl/as_sc_cell_bist.sv
// BIST sequencer for the mcu7t3v3 cell test bank: drives LFSR stimulus into the
// cells and folds their responses into a 16-bit MISR for a golden compare.
module as_sc_cell_bist #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned N_OUT = 16,
    parameter int unsigned N_PAT = 255,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VDD,
    input  logic             VSS,
    input  logic             VPW,
    input  logic             VNW,
    input  logic             START,
    input  logic [15:0]      GOLDEN,
    input  logic [N_OUT-1:0] RESP,
    output logic [N_IN-1:0]  STIM,
    output logic             BUSY,
    output logic             DONE,
    output logic [15:0]      SIG,
    output logic             PASS
);

    localparam int unsigned SIG_W    = 16;
    localparam logic [15:0] CNT_LAST = 16'(N_PAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] lfsr_q, lfsr_d;
    logic [SIG_W-1:0] misr_q, misr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [SIG_W-1:0] resp_q, resp_d;
    logic             vld_q, vld_d;
    logic [N_IN-1:0]  stim_d;
    logic             busy_d, done_d;
    logic [SIG_W-1:0] lfsr_adv;
    logic [SIG_W-1:0] resp_ext;
    logic             unused_pins;

    // Shared x^16+x^14+x^13+x^11+1 shift step for both the LFSR and the MISR
    function automatic logic [SIG_W-1:0] step(input logic [SIG_W-1:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign lfsr_adv    = step(lfsr_q);
    assign resp_ext    = SIG_W'(RESP);
    assign unused_pins = ^{VDD, VSS, VPW, VNW};

    // Next-state and datapath: lfsr always holds the pattern currently on STIM
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        vld_d   = vld_q;
        stim_d  = STIM;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_RUN;
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    cnt_d   = '0;
                    vld_d   = 1'b0;
                    stim_d  = SEED[N_IN-1:0];
                end
            end
            S_RUN: begin
                resp_d = resp_ext;
                vld_d  = 1'b1;
                if (vld_q) begin
                    misr_d = step(misr_q) ^ resp_q;
                end
                cnt_d  = cnt_q + 16'd1;
                lfsr_d = lfsr_adv;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                    stim_d  = '0;
                end else begin
                    stim_d  = lfsr_adv[N_IN-1:0];
                end
            end
            S_DRAIN: begin
                // Last pattern's response is still in resp_q; fold it once more
                misr_d  = step(misr_q) ^ resp_q;
                vld_d   = 1'b0;
                stim_d  = '0;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                stim_d  = '0;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            vld_q   <= 1'b0;
            STIM    <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            vld_q   <= vld_d;
            STIM    <= stim_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
        end
    end

    assign SIG  = misr_q;
    assign PASS = DONE && (misr_q == GOLDEN);

endmodule

// File: doc/as_sc_cell_bist.md
# as_sc_cell_bist

Built-in self-test sequencer for the mcu7t3v3 cell library test bank. It drives pseudo-random stimulus vectors into a bank of combinational cells under test and compacts their responses into a 16-bit multiple-input signature register (MISR). It then compares the signature against a golden value. It sits between the chip test controller (START/DONE handshake) and the cell test bank (STIM out, RESP in).

## Interface
- N_IN, 8: stimulus width, 1..16.
- N_OUT, 16: response width, 1..16. RESP is zero-extended to 16 bits.
- N_PAT, 255: patterns per run, 1..65535.
- SEED, 16'hACE1: LFSR load value. Must be nonzero.

- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- VDD, VSS, VPW, VNW  in  1 each  supply and well pins; functionally unused.
- START  in  1  run request; sampled in IDLE and DONE.
- GOLDEN  in  16  expected signature.
- RESP  in  N_OUT  cell-bank response to STIM.
- STIM  out  N_IN  stimulus vector, registered.
- BUSY  out  1  high in RUN and DRAIN.
- DONE  out  1  high in DONE state.
- SIG  out  16  MISR contents.
- PASS  out  1  (SIG == GOLDEN) while DONE; 0 otherwise.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset (RST_N=0 at an edge), from any state including mid-run:
  - state=IDLE.
  - lfsr=SEED, misr=0, cnt=0, resp_q=0, vld_q=0.
  - STIM=0, BUSY=0, DONE=0, PASS=0, SIG=0.
- IDLE, START=1 → RUN: lfsr=SEED, misr=0, cnt=0, vld_q=0.
- RUN, each cycle:
  - STIM=lfsr[N_IN-1:0].
  - lfsr advances Fibonacci: fb=l[15]^l[13]^l[12]^l[10]; next={l[14:0],fb}.
  - resp_q<=RESP, vld_q<=1.
  - if vld_q: misr<={m[14:0], m[15]^m[13]^m[12]^m[10]} ^ resp_q.
  - cnt<=cnt+1.
  - When cnt==N_PAT-1 → DRAIN.
- DRAIN, one cycle:
  - STIM=0.
  - Final misr fold of resp_q (last pattern's response) and of RESP captured in the same edge as required by pipeline; precisely, misr folds resp_q, then → DONE.
- DONE:
  - DONE=1, SIG holds, PASS=(SIG==GOLDEN) live against GOLDEN.
  - START=1 → RUN with the same init as from IDLE. DONE drops the next cycle.
- START while BUSY is ignored.
- cnt is 16 bits; it never wraps because the exit occurs at N_PAT-1.
- Width rules: RESP is zero-extended to 16 bits before the XOR. STIM takes the lfsr LSBs.

## Timing
- Edge e0 samples START=1. Pattern k (k=0..N_PAT-1) is driven on STIM between e_k and e_{k+1}.
- RESP for pattern k is captured into resp_q at e_{k+1} and folded into misr at e_{k+2}.
- Pattern 0 on STIM equals SEED[N_IN-1:0]. Pattern 1 is the first LFSR successor.
- BUSY=1 from after e0 through e_{N_PAT+1}.
- DONE=1 and the final SIG are valid after e_{N_PAT+1}. Total latency is N_PAT+1 cycles from the START-sampling edge.
- The cell bank must settle within one CLK period; RESP is sampled exactly once per pattern.
- Exactly N_PAT responses are compacted per run; no stray fold of a stale resp_q at run start, because vld_q=0 on the first RUN cycle.
- START held high continuously: back-to-back runs. DONE is high for exactly 1 cycle between runs, and SIG is identical each run for a deterministic bank.

## Test plan
- Reset: assert RST_N=0 for 2 edges with START=1 → STIM=0, BUSY=0, DONE=0, SIG=16'h0000, PASS=0. State stays IDLE until RST_N=1.
- Zero response: RESP=0, GOLDEN=0, N_PAT=255, pulse START → BUSY for 256 cycles, DONE after e256, SIG=16'h0000, PASS=1. STIM sequence matches the LFSR model starting at 8'hE1.
- Echo bank: RESP=zero-extended STIM, N_PAT=255 → SIG equals the bit-exact model value. GOLDEN=model gives PASS=1; GOLDEN=model^16'h0001 gives PASS=0.
- Boundary N_PAT=1: START → one pattern (STIM=SEED[N_IN-1:0]), DONE after e2. With RESP=16'h0001, SIG=16'h0001.
- Fault injection: echo bank with bit 3 of RESP stuck at 1 for one pattern only (k=100) → SIG differs from the golden value and PASS=0. START pulses during BUSY have no effect on the cycle count.
- Reset mid-run: RST_N=0 at e50 of a run → IDLE next cycle, all outputs at reset values. A subsequent START reproduces the golden SIG exactly.
